main_mem_ctrl: RTL and testbench
================================

MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

Interface
REQ-001 Parameter DEPTH, default 1024: backing store size in 32-bit words; power of two.
REQ-002 Parameter READ_LAT, default 20: cycles from read acceptance to ReadReady; legal range 1..255.
REQ-003 Parameter WRITE_LAT, default 20: cycles from write acceptance to WriteReady; legal range 1..255.
REQ-004 Clk  input  1  sole clock; all state changes on rising edge.
REQ-005 Rst  input  1  synchronous, active-high reset.
REQ-006 Address  input  32  byte address from cache; bits [1:0] ignored.
REQ-007 ReadMiss  input  1  level request for a 4-word block read.
REQ-008 MemWriteThrough  input  1  level request for a single-word write.
REQ-009 Write_data  input  32  write word, sampled at write acceptance.
REQ-010 Abort  input  1  cancels a pending read; present only under MAIN_MEM_CTRL_ABORT_EN.
REQ-011 Read_data  output  128  block data; word at block offset 0 in [31:0], offset 3 in [127:96].
REQ-012 ReadReady  output  1  one-cycle pulse: Read_data valid.
REQ-013 WriteReady  output  1  one-cycle pulse: write committed.
REQ-014 Busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, READ_WAIT, WRITE_WAIT, DONE.
REQ-016 In IDLE, MemWriteThrough high SHALL accept a write: latch word index Address[log2(DEPTH)+1:2] and Write_data, load counter with WRITE_LAT-1, go to WRITE_WAIT.
REQ-017 In IDLE, ReadMiss high with MemWriteThrough low SHALL accept a read: latch block index Address[log2(DEPTH)+1:4], load counter with READ_LAT-1, go to READ_WAIT.
REQ-018 Simultaneous ReadMiss and MemWriteThrough in IDLE: write wins; read is accepted in a later IDLE cycle if still asserted.
REQ-019 Address bits above log2(DEPTH)+1 SHALL be ignored (address wraps modulo DEPTH words).
REQ-020 READ_WAIT/WRITE_WAIT decrement counter each cycle; ReadReady/WriteReady SHALL assert in the cycle counter equals 0, exactly READ_LAT/WRITE_LAT cycles after the accepting edge; next state DONE.
REQ-021 Read_data SHALL be loaded with the 4 words of the latched block in the ReadReady cycle and held unchanged until the next ReadReady.
REQ-022 Write SHALL update the store on the edge ending the WriteReady cycle; a read accepted afterwards returns the new word.
REQ-023 DONE SHALL last exactly one cycle, accept no request, then return to IDLE (gives requester one cycle to drop its level request).
REQ-024 Requests arriving while Busy SHALL be ignored, not queued; input changes during WAIT states SHALL not affect the latched operation.
REQ-025 ReadReady and WriteReady SHALL never be high in the same cycle.

Reset
REQ-026 Rst high at a rising edge SHALL force IDLE, counter 0, ReadReady 0, WriteReady 0, Busy 0, Read_data 0, regardless of state.
REQ-027 Reset mid-operation SHALL drop the operation: no response pulse, pending write not committed.
REQ-028 Store contents SHALL not be cleared by Rst.

Configuration
REQ-029 Macro MAIN_MEM_CTRL_ABORT_EN defined: Abort port exists; Abort high in READ_WAIT SHALL go to IDLE next cycle with no ReadReady and Read_data unchanged; Abort in other states ignored; Abort never cancels writes.
REQ-030 Macro undefined: no Abort port; every accepted read completes per REQ-020.

Verification
REQ-031 Write 0xDEADBEEF to 0x0000_0044 (WRITE_LAT=20) -> WriteReady pulse exactly 20 cycles after acceptance, Busy high 21 cycles incl. DONE.
REQ-032 After REQ-031, ReadMiss at 0x0000_0048 -> ReadReady 20 cycles later, Read_data[63:32]=0xDEADBEEF (word offset 1 of block 0x40).
REQ-033 ReadMiss and MemWriteThrough both high at 0x0000_0100 -> WriteReady first; read accepted after DONE if held; read returns written word.
REQ-034 Rst pulsed 5 cycles into write of 0x12345678 to 0x0000_0200 -> no WriteReady, all outputs 0; later read of 0x200 returns prior contents.
REQ-035 DEPTH=1024, read at 0x0000_1010 -> same data as 0x0000_0010 (wrap).
REQ-036 MAIN_MEM_CTRL_ABORT_EN: Abort 3 cycles into read -> IDLE next cycle, no ReadReady, Read_data holds previous block.

Source files
------------

// File: rtl/main_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// main_mem_ctrl_if
// Bundle of the cache <-> main-memory request/response signals.
//
// Signals:
//   Address          cache -> mem  32   byte address (bits [1:0] unused)
//   ReadMiss         cache -> mem  1    level request, 4-word block read
//   MemWriteThrough  cache -> mem  1    level request, single-word write
//   Write_data       cache -> mem  32   write word
//   Abort            cache -> mem  1    cancel pending read (only when
//                                       MAIN_MEM_CTRL_ABORT_EN is defined)
//   Read_data        mem -> cache  128  block data, offset 0 in [31:0]
//   ReadReady        mem -> cache  1    one-cycle pulse, Read_data valid
//   WriteReady       mem -> cache  1    one-cycle pulse, write committed
//   Busy             mem -> cache  1    controller not idle
//
// Modports: master (cache side), slave (memory controller side).
// Optional feature macro: MAIN_MEM_CTRL_ABORT_EN
// -----------------------------------------------------------------------------
interface main_mem_ctrl_if;
  logic [31:0]  Address;
  logic         ReadMiss;
  logic         MemWriteThrough;
  logic [31:0]  Write_data;
`ifdef MAIN_MEM_CTRL_ABORT_EN
  logic         Abort;
`endif
  logic [127:0] Read_data;
  logic         ReadReady;
  logic         WriteReady;
  logic         Busy;

`ifdef MAIN_MEM_CTRL_ABORT_EN
  modport master (
    output Address, ReadMiss, MemWriteThrough, Write_data, Abort,
    input  Read_data, ReadReady, WriteReady, Busy
  );
  modport slave (
    input  Address, ReadMiss, MemWriteThrough, Write_data, Abort,
    output Read_data, ReadReady, WriteReady, Busy
  );
`else
  modport master (
    output Address, ReadMiss, MemWriteThrough, Write_data,
    input  Read_data, ReadReady, WriteReady, Busy
  );
  modport slave (
    input  Address, ReadMiss, MemWriteThrough, Write_data,
    output Read_data, ReadReady, WriteReady, Busy
  );
`endif
endinterface

// File: rtl/main_mem_ctrl.sv
// -----------------------------------------------------------------------------
// main_mem_ctrl
// Fixed-latency main-memory model/controller behind a write-through cache.
// Serves 4-word block reads and single-word writes from a DEPTH-word store,
// answering each accepted request exactly READ_LAT / WRITE_LAT cycles later.
//
// Parameters:
//   DEPTH      store size in 32-bit words (power of two, >= 4)
//   READ_LAT   cycles from read acceptance to ReadReady   (1..255)
//   WRITE_LAT  cycles from write acceptance to WriteReady (1..255)
//
// Ports:
//   Clk   input  sole clock, rising edge
//   Rst   input  synchronous active-high reset (store contents are kept)
//   bus   main_mem_ctrl_if.slave  request/response bundle
//
// Optional feature macro: MAIN_MEM_CTRL_ABORT_EN
//   Defined   -> bus.Abort cancels a read still waiting in READ_WAIT.
//   Undefined -> no Abort signal; every accepted read completes.
// -----------------------------------------------------------------------------
module main_mem_ctrl #(
  parameter int DEPTH     = 1024,
  parameter int READ_LAT  = 20,
  parameter int WRITE_LAT = 20
) (
  input  logic           Clk,
  input  logic           Rst,
  main_mem_ctrl_if.slave bus
);

  localparam int AW   = $clog2(DEPTH);  // word index width
  localparam int BW   = AW - 2;         // block index width
  localparam int ROWS = DEPTH / 4;      // words per bank

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, DONE} state_t;

  state_t         stateReg, stateNext;
  logic [7:0]     countReg;
  logic [AW-1:0]  wordIdxReg;
  logic [BW-1:0]  blockIdxReg;
  logic [31:0]    wrDataReg;
  logic [BW-1:0]  loadIdx;
  logic [127:0]   readBlock;

  logic abortReq;
  logic acceptWrite, acceptRead;
  logic readDone, writeDone, abortHit;
  logic loadReadData, commitWrite;

  // Address bits above the store and the byte offset are don't-care.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{bus.Address[31:AW+2], bus.Address[1:0]};

`ifdef MAIN_MEM_CTRL_ABORT_EN
  assign abortReq = bus.Abort;
`else
  assign abortReq = 1'b0;
`endif

  // Write has priority over a simultaneous read request.
  assign acceptWrite = (stateReg == IDLE) && bus.MemWriteThrough;
  assign acceptRead  = (stateReg == IDLE) && bus.ReadMiss && !bus.MemWriteThrough;
  assign readDone    = (stateReg == READ_WAIT)  && (countReg == 8'd0);
  assign writeDone   = (stateReg == WRITE_WAIT) && (countReg == 8'd0);
  // Once the response cycle has arrived the read can no longer be cancelled,
  // so Read_data and ReadReady stay consistent.
  assign abortHit    = (stateReg == READ_WAIT) && abortReq && (countReg != 8'd0);

  // The block is fetched on the edge that starts the ReadReady cycle; with a
  // one-cycle latency that is the accepting edge itself.
  assign loadReadData = (acceptRead && (READ_LAT == 1)) ||
                        ((stateReg == READ_WAIT) && (countReg == 8'd1) && !abortReq);
  assign loadIdx      = (stateReg == IDLE) ? bus.Address[AW+1:4] : blockIdxReg;

  // Commit on the edge closing the WriteReady cycle unless reset wins.
  assign commitWrite  = writeDone && !Rst;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clk) begin
    if (Rst) stateReg <= IDLE;
    else     stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (acceptWrite)     stateNext = WRITE_WAIT;
        else if (acceptRead) stateNext = READ_WAIT;
      end
      READ_WAIT: begin
        if (abortHit)                 stateNext = IDLE;
        else if (countReg == 8'd0)    stateNext = DONE;
      end
      WRITE_WAIT: begin
        if (countReg == 8'd0)         stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    bus.ReadReady  = readDone;
    bus.WriteReady = writeDone;
    bus.Busy       = (stateReg != IDLE);
  end

  assign bus.Read_data = readBlock;

  // ------------------------------------------------------------ datapath
  always_ff @(posedge Clk) begin
    if (Rst) begin
      countReg    <= 8'd0;
      wordIdxReg  <= '0;
      blockIdxReg <= '0;
      wrDataReg   <= 32'd0;
    end else if (acceptWrite) begin
      countReg   <= 8'(WRITE_LAT - 1);
      wordIdxReg <= bus.Address[AW+1:2];
      wrDataReg  <= bus.Write_data;
    end else if (acceptRead) begin
      countReg    <= 8'(READ_LAT - 1);
      blockIdxReg <= bus.Address[AW+1:4];
    end else if (abortHit) begin
      countReg <= 8'd0;
    end else if (countReg != 8'd0) begin
      countReg <= countReg - 8'd1;
    end
  end

  // ------------------------------------------------------------ store
  // Four word-wide banks so a whole block is read in one access; bank gi
  // holds block offset gi. The registered read port doubles as Read_data.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gBank
      logic [31:0] bankMem [ROWS];
      logic [31:0] wordOut;

      always_ff @(posedge Clk) begin
        if (commitWrite && (wordIdxReg[1:0] == 2'(gi)))
          bankMem[wordIdxReg[AW-1:2]] <= wrDataReg;
      end

      always_ff @(posedge Clk) begin
        if (Rst)               wordOut <= 32'd0;
        else if (loadReadData) wordOut <= bankMem[loadIdx];
      end

      assign readBlock[gi*32 +: 32] = wordOut;
    end
  endgenerate

endmodule

// File: tb/tb_main_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_main_mem_ctrl
// Directed bench for main_mem_ctrl (DEPTH=1024, READ_LAT=WRITE_LAT=20).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Define MAIN_MEM_CTRL_ABORT_EN to also exercise the Abort path.
// -----------------------------------------------------------------------------
module tb_main_mem_ctrl;

  localparam int LAT = 20;

  logic Clk = 1'b0;
  logic Rst;

  main_mem_ctrl_if bus ();

  main_mem_ctrl #(.DEPTH(1024), .READ_LAT(LAT), .WRITE_LAT(LAT)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starting in the first cycle after the accepting edge, walk the operation
  // until Busy drops (bounded), recording where the expected pulse appeared.
  task automatic runOp(input bit isRead, output int lat, output int pulses,
                       output int busyCyc, output int wrong);
    lat = 0; pulses = 0; busyCyc = 0; wrong = 0;
    for (int n = 1; n <= 100 && bus.Busy; n++) begin
      busyCyc++;
      if (isRead ? bus.ReadReady : bus.WriteReady) begin
        pulses++;
        lat = n;
      end
      if (isRead ? bus.WriteReady : bus.ReadReady) wrong++;
      tick();
    end
  endtask

  task automatic finishOp(input string tag, input bit isRead);
    int lat, pulses, busyCyc, wrong;
    runOp(isRead, lat, pulses, busyCyc, wrong);
    check({tag, "_lat"},    128'(lat),     128'(LAT));
    check({tag, "_pulses"}, 128'(pulses),  128'd1);
    check({tag, "_busy"},   128'(busyCyc), 128'(LAT + 1));
    check({tag, "_other"},  128'(wrong),   128'd0);
    $display("%s %s: latency %0d, busy %0d cycles", isRead ? "read " : "write", tag, lat, busyCyc);
  endtask

  task automatic doWrite(input string tag, input logic [31:0] addr, input logic [31:0] data);
    bus.Address = addr;
    bus.Write_data = data;
    bus.MemWriteThrough = 1'b1;
    tick();
    bus.MemWriteThrough = 1'b0;
    finishOp(tag, 1'b0);
  endtask

  task automatic doRead(input string tag, input logic [31:0] addr);
    bus.Address = addr;
    bus.ReadMiss = 1'b1;
    tick();
    bus.ReadMiss = 1'b0;
    finishOp(tag, 1'b1);
  endtask

  initial begin
    int wrSeen;
    int rdSeen;

    Rst = 1'b1;
    bus.Address = 32'd0;
    bus.ReadMiss = 1'b0;
    bus.MemWriteThrough = 1'b0;
    bus.Write_data = 32'd0;
`ifdef MAIN_MEM_CTRL_ABORT_EN
    bus.Abort = 1'b0;
`endif
    tick();
    tick();
    check("rst_busy",  128'(bus.Busy),       128'd0);
    check("rst_rdy_r", 128'(bus.ReadReady),  128'd0);
    check("rst_rdy_w", 128'(bus.WriteReady), 128'd0);
    check("rst_rdata", bus.Read_data,        128'd0);
    Rst = 1'b0;
    tick();

    // Write then read back within the same block.
    doWrite("wr44", 32'h0000_0044, 32'hDEAD_BEEF);
    doRead("rd48", 32'h0000_0048);
    check("rd48_word1", 128'(bus.Read_data[63:32]), 128'h DEAD_BEEF);
    tick(); tick(); tick();
    check("rd48_hold", 128'(bus.Read_data[63:32]), 128'h DEAD_BEEF);

    // Simultaneous requests: write first, held read served afterwards.
    bus.Address = 32'h0000_0100;
    bus.Write_data = 32'hCAFE_F00D;
    bus.ReadMiss = 1'b1;
    bus.MemWriteThrough = 1'b1;
    tick();
    bus.MemWriteThrough = 1'b0;
    bus.Write_data = 32'h1111_1111;   // must not disturb the latched write
    finishOp("both_wr", 1'b0);
    tick();                           // held ReadMiss accepted on this edge
    bus.ReadMiss = 1'b0;
    finishOp("both_rd", 1'b1);
    check("both_rd_word0", 128'(bus.Read_data[31:0]), 128'h CAFE_F00D);

    // Reset in the middle of a write drops it.
    doWrite("wr200_a", 32'h0000_0200, 32'hA5A5_A5A5);
    bus.Address = 32'h0000_0200;
    bus.Write_data = 32'h1234_5678;
    bus.MemWriteThrough = 1'b1;
    tick();
    bus.MemWriteThrough = 1'b0;
    wrSeen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.WriteReady) wrSeen++;
      tick();
    end
    Rst = 1'b1;
    tick();
    check("midrst_busy",  128'(bus.Busy),       128'd0);
    check("midrst_rdy_r", 128'(bus.ReadReady),  128'd0);
    check("midrst_rdy_w", 128'(bus.WriteReady), 128'd0);
    check("midrst_rdata", bus.Read_data,        128'd0);
    Rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (bus.WriteReady) wrSeen++;
      tick();
    end
    check("midrst_no_wr", 128'(wrSeen), 128'd0);
    $display("reset during write 0x200: WriteReady pulses seen %0d", wrSeen);
    doRead("rd200", 32'h0000_0200);
    check("rd200_prior", 128'(bus.Read_data[31:0]), 128'h A5A5_A5A5);

    // Address wrap modulo DEPTH words.
    doWrite("wr14", 32'h0000_0014, 32'h0BAD_F00D);
    doWrite("wrF018", 32'hFFFF_F018, 32'h600D_CAFE);
    doRead("rd1010", 32'h0000_1010);
    check("rd1010_word1", 128'(bus.Read_data[63:32]), 128'h0BAD_F00D);
    check("rd1010_word2", 128'(bus.Read_data[95:64]), 128'h600D_CAFE);
    doRead("rd10", 32'h0000_0010);
    check("rd10_word1", 128'(bus.Read_data[63:32]), 128'h0BAD_F00D);
    check("rd10_word2", 128'(bus.Read_data[95:64]), 128'h600D_CAFE);

`ifdef MAIN_MEM_CTRL_ABORT_EN
    // Abort three cycles into a read.
    bus.Address = 32'h0000_0044;
    bus.ReadMiss = 1'b1;
    tick();
    bus.ReadMiss = 1'b0;
    rdSeen = 0;
    for (int i = 0; i < 2; i++) begin
      if (bus.ReadReady) rdSeen++;
      tick();
    end
    bus.Abort = 1'b1;
    tick();
    bus.Abort = 1'b0;
    check("abort_busy", 128'(bus.Busy), 128'd0);
    for (int i = 0; i < 25; i++) begin
      if (bus.ReadReady) rdSeen++;
      tick();
    end
    check("abort_no_rd", 128'(rdSeen), 128'd0);
    check("abort_hold", 128'(bus.Read_data[63:32]), 128'h0BAD_F00D);
    $display("abort read 0x44: ReadReady pulses seen %0d", rdSeen);
`else
    rdSeen = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
